layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised successor to the fixed five-input video mux. Merges NUM_LAYERS painter outputs by fixed priority into one registered pixel stream.
- Delays hsync/vsync to stay aligned with the pixel pipeline.
- Detects every pairwise layer overlap: a live per-pixel vector plus per-frame sticky snapshots for game logic.
- Sits between the painters and the VGA pins.

Parameters:
- NUM_LAYERS, 4, number of layers; layer 0 has the highest priority; legal range 2..8.
- COLOR_BITS, 6, bits per pixel colour (2R/2G/2B packing unchanged).
- PIPE_STAGES, 1, pixel/sync latency in clocks; legal range 1..3.
- NPAIRS, NUM_LAYERS*(NUM_LAYERS-1)/2, derived localparam; not to be overridden.

Ports:
- clk  in  1  pixel clock
- nRst  in  1  asynchronous active-low reset
- layer_color  in  NUM_LAYERS*COLOR_BITS  colour of layer k at bits [k*COLOR_BITS +: COLOR_BITS]
- layer_en  in  NUM_LAYERS  layer k pixel present
- background  in  COLOR_BITS  colour when no layer is enabled
- in_frame  in  1  active video region
- hsync_in  in  1  from vga_timing
- vsync_in  in  1  from vga_timing
- frame_pulse  in  1  one-cycle start-of-frame strobe
- pix_out  out  COLOR_BITS  composited pixel
- hsync_out  out  1  hsync delayed by PIPE_STAGES
- vsync_out  out  1  vsync delayed by PIPE_STAGES
- coll_live  out  NPAIRS  registered per-pixel overlap, 1-cycle latency
- coll_frame  out  NPAIRS  sticky overlap set of the previous completed frame
- coll_valid  out  1  high once at least one frame has been snapshotted

Behaviour:
- Reset (async, nRst=0):
  - pix_out, coll_live, coll_frame, accumulator and coll_valid are 0.
  - hsync_out and vsync_out are 1 (inactive, negative sync).
  - All pipeline stages clear to the same values.
- Composition:
  - Selected colour = colour of the lowest-index k with layer_en[k]=1; otherwise background.
  - If in_frame=0, the colour is forced to 0, whatever the enables.
- Pixel pipeline:
  - The selected colour passes through exactly PIPE_STAGES registers to pix_out.
  - hsync_in, vsync_in and in_frame pass through identical-length shift registers.
  - Input on cycle t appears on outputs at cycle t+PIPE_STAGES.
- Pair index:
  - Pairs (i,j) with i<j are enumerated lexicographically: (0,1)=0, (0,2)=1, … (N-2,N-1)=NPAIRS-1.
  - pair_hit[p] = layer_en[i] & layer_en[j] & in_frame.
- coll_live: registered pair_hit, latency 1, independent of PIPE_STAGES.
- Frame accumulator acc[NPAIRS]:
  - Each cycle: acc <= acc | pair_hit.
  - On frame_pulse: coll_frame <= acc (excluding the current cycle's hits); acc <= pair_hit (the current cycle's hits belong to the new frame); coll_valid <= 1.
  - coll_frame changes only on the cycle after frame_pulse and holds for the whole frame.
  - frame_pulse on consecutive cycles: each one snapshots; the second snapshot holds only the first cycle's hits.
- Reset mid-frame: all state clears immediately; coll_valid stays 0 until the next frame_pulse.
- Width rules:
  - No arithmetic on colours.
  - Pair index and loop bounds are computed at elaboration with integer loops.
  - No latches; all outputs driven from flops.

Optional Feature:
- Macro COMPOSITOR_LAYER_MASK_EN.
- When defined, the block adds input layer_mask [NUM_LAYERS]:
  - A layer with layer_mask[k]=1 is excluded from composition (treated as not enabled for colour selection).
  - It still participates in pair_hit (invisible hitboxes, e.g. ball ghost mode).
  - layer_mask is sampled in the same cycle as layer_en.
- When undefined, the port does not exist and every enabled layer is drawn.

Test Plan:
- Reset/latency: hold nRst=0, then release. All outputs are 0 except hsync_out=vsync_out=1. With PIPE_STAGES=2, drive layer_en=4'b0100, layer 2 colour 6'h2A, in_frame=1 at cycle t → pix_out=6'h2A at t+2; hsync_in toggle at t → hsync_out toggles at t+2.
- Priority: layer_en=4'b1110, colours L1=6'h03, L2=6'h0C, L3=6'h30 → pix_out=6'h03. layer_en=0, background=6'h15 → 6'h15. in_frame=0 with layer_en=4'b1111 → 6'h00.
- Pair mapping (NUM_LAYERS=4): layer_en=4'b1001, in_frame=1 → coll_live=6'b000100 (pair (0,3), index 2) one cycle later. layer_en=4'b0110 → 6'b001000 (pair (1,2), index 3).
- Frame snapshot:
  - Pair (0,1) hits mid-frame; frame_pulse → next cycle coll_frame=6'b000001, coll_valid=1.
  - Quiet frame, then frame_pulse → coll_frame=0.
  - A hit on the frame_pulse cycle itself is absent from that snapshot and present in the following one.
- Async reset mid-frame: accumulate pair 5, assert nRst=0 between clock edges → coll_frame, coll_live and acc clear immediately. After release, coll_valid=0 until the next frame_pulse.
- COMPOSITOR_LAYER_MASK_EN defined: layer_en=4'b0011, layer_mask=4'b0001, L0=6'h3F, L1=6'h0C → pix_out=6'h0C and coll_live[0]=1.

Source files
------------

// File: rtl/layer_compositor.sv
// Priority compositor: merges NUM_LAYERS painter outputs (layer 0 on top) into one registered pixel stream, with pairwise overlap detection.
// Latency: pix_out/hsync_out/vsync_out PIPE_STAGES clocks; coll_live 1 clock; coll_frame updates the clock after frame_pulse.
// Backpressure: none, free-running pixel stream; every input is consumed on every clock.
//
// Ports:
//   clk, nRst             pixel clock, asynchronous active-low reset
//   layer_color/layer_en  per-layer colour (k at [k*COLOR_BITS +: COLOR_BITS]) and pixel-present flag
//   background            colour used when no layer is drawn
//   in_frame              active video; outside it the pixel is blanked to 0
//   hsync_in/vsync_in     negative syncs, delayed to hsync_out/vsync_out to stay aligned with pix_out
//   frame_pulse           start-of-frame strobe; snapshots the overlap accumulator into coll_frame
//   coll_live             per-pixel pair overlap vector; pair (i,j), i<j, enumerated lexicographically
//   coll_valid            set by the first snapshot after reset
//
// Optional build macro COMPOSITOR_LAYER_MASK_EN adds input layer_mask: a masked layer is not drawn but
// still takes part in overlap detection.
module layer_compositor #(
    parameter int  NUM_LAYERS  = 4,
    parameter int  COLOR_BITS  = 6,
    parameter int  PIPE_STAGES = 1,
    localparam int NPAIRS      = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
    input  logic                             clk,
    input  logic                             nRst,
    input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]            layer_en,
`ifdef COMPOSITOR_LAYER_MASK_EN
    input  logic [NUM_LAYERS-1:0]            layer_mask,
`endif
    input  logic [COLOR_BITS-1:0]            background,
    input  logic                             in_frame,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    input  logic                             frame_pulse,
    output logic [COLOR_BITS-1:0]            pix_out,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic [NPAIRS-1:0]                coll_live,
    output logic [NPAIRS-1:0]                coll_frame,
    output logic                             coll_valid
);

    // Elaboration-time guard on the supported parameter ranges.
    if (NUM_LAYERS < 2 || NUM_LAYERS > 8) begin : g_bad_layers
        $error("layer_compositor: NUM_LAYERS must be in 2..8");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_pipe
        $error("layer_compositor: PIPE_STAGES must be in 1..3");
    end

    // ------------------------------------------------------------------
    // Colour selection
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] draw_en;

`ifdef COMPOSITOR_LAYER_MASK_EN
    assign draw_en = layer_en & ~layer_mask;
`else
    assign draw_en = layer_en;
`endif

    logic [COLOR_BITS-1:0] sel_color;

    // Walk from the lowest priority upwards so the last hit (lowest index) wins.
    // Blanking is applied here, at the head of the pipeline, so the colour
    // stages already carry the in_frame qualification with identical delay.
    always_comb begin
        sel_color = background;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (draw_en[k]) begin
                sel_color = layer_color[k*COLOR_BITS +: COLOR_BITS];
            end
        end
        if (!in_frame) begin
            sel_color = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pixel / sync pipeline, PIPE_STAGES deep
    // ------------------------------------------------------------------
    logic [COLOR_BITS-1:0]  pix_pipe [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] hs_pipe;
    logic [PIPE_STAGES-1:0] vs_pipe;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                pix_pipe[s] <= '0;
            end
            hs_pipe <= '1;      // syncs idle high (negative polarity)
            vs_pipe <= '1;
        end else begin
            pix_pipe[0] <= sel_color;
            hs_pipe[0]  <= hsync_in;
            vs_pipe[0]  <= vsync_in;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                pix_pipe[s] <= pix_pipe[s-1];
                hs_pipe[s]  <= hs_pipe[s-1];
                vs_pipe[s]  <= vs_pipe[s-1];
            end
        end
    end

    assign pix_out   = pix_pipe[PIPE_STAGES-1];
    assign hsync_out = hs_pipe[PIPE_STAGES-1];
    assign vsync_out = vs_pipe[PIPE_STAGES-1];

    // ------------------------------------------------------------------
    // Pairwise overlap detection
    // ------------------------------------------------------------------
    logic [NPAIRS-1:0] pair_hit;

    // Pair (i,j) index: pairs before row i number i*(2N-i-1)/2, then offset j-i-1.
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_row
        for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_col
            localparam int PIDX = i * (2 * NUM_LAYERS - i - 1) / 2 + (j - i - 1);
            assign pair_hit[PIDX] = layer_en[i] & layer_en[j] & in_frame;
        end
    end

    logic [NPAIRS-1:0] acc;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            coll_live  <= '0;
            coll_frame <= '0;
            acc        <= '0;
            coll_valid <= 1'b0;
        end else begin
            coll_live <= pair_hit;
            if (frame_pulse) begin
                // Hits on the strobe cycle belong to the frame that is starting.
                coll_frame <= acc;
                acc        <= pair_hit;
                coll_valid <= 1'b1;
            end else begin
                acc <= acc | pair_hit;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CB = 6;
    localparam int PS = 2;
    localparam int NP = NL * (NL - 1) / 2;

    logic               clk;
    logic               nRst;
    logic [NL*CB-1:0]   layer_color;
    logic [NL-1:0]      layer_en;
`ifdef COMPOSITOR_LAYER_MASK_EN
    logic [NL-1:0]      layer_mask;
`endif
    logic [CB-1:0]      background;
    logic               in_frame;
    logic               hsync_in;
    logic               vsync_in;
    logic               frame_pulse;
    logic [CB-1:0]      pix_out;
    logic               hsync_out;
    logic               vsync_out;
    logic [NP-1:0]      coll_live;
    logic [NP-1:0]      coll_frame;
    logic               coll_valid;

    int n_checks = 0;
    int n_fails  = 0;

    layer_compositor #(
        .NUM_LAYERS (NL),
        .COLOR_BITS (CB),
        .PIPE_STAGES(PS)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .layer_color(layer_color),
        .layer_en   (layer_en),
`ifdef COMPOSITOR_LAYER_MASK_EN
        .layer_mask (layer_mask),
`endif
        .background (background),
        .in_frame   (in_frame),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .frame_pulse(frame_pulse),
        .pix_out    (pix_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .coll_live  (coll_live),
        .coll_frame (coll_frame),
        .coll_valid (coll_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 ns after the edge so outputs are settled.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic set_colors(input logic [CB-1:0] l0, input logic [CB-1:0] l1,
                              input logic [CB-1:0] l2, input logic [CB-1:0] l3);
        layer_color = {l3, l2, l1, l0};
    endtask

    initial begin
        nRst        = 1'b0;
        layer_color = '0;
        layer_en    = '0;
`ifdef COMPOSITOR_LAYER_MASK_EN
        layer_mask  = '0;
`endif
        background  = '0;
        in_frame    = 1'b0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        frame_pulse = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_pix",   pix_out,    0);
        check("rst_hs",    hsync_out,  1);
        check("rst_vs",    vsync_out,  1);
        check("rst_live",  coll_live,  0);
        check("rst_frame", coll_frame, 0);
        check("rst_valid", coll_valid, 0);
        nRst = 1'b1;
        step();

        // ---- latency with PIPE_STAGES=2 ----
        set_colors(6'h00, 6'h00, 6'h2A, 6'h00);
        layer_en = 4'b0100;
        in_frame = 1'b1;
        hsync_in = 1'b0;
        step();
        check("lat_pix_t1",  pix_out,   6'h00);
        check("lat_hs_t1",   hsync_out, 1);
        check("lat_live_1p", coll_live, 0);
        step();
        check("lat_pix_t2",  pix_out,   6'h2A);
        check("lat_hs_t2",   hsync_out, 0);
        check("lat_vs_t2",   vsync_out, 1);

        // ---- priority ----
        set_colors(6'h00, 6'h03, 6'h0C, 6'h30);
        layer_en = 4'b1110;
        step();
        check("prio_live", coll_live, 6'b111000);
        step();
        check("prio_l1", pix_out, 6'h03);

        layer_en   = 4'b0000;
        background = 6'h15;
        step(2);
        check("prio_bg", pix_out, 6'h15);

        layer_en = 4'b1111;
        in_frame = 1'b0;
        step();
        check("blank_live", coll_live, 0);
        step();
        check("blank_pix", pix_out, 6'h00);

        // ---- pair mapping ----
        in_frame = 1'b1;
        layer_en = 4'b1001;
        step();
        check("pair_0_3", coll_live, 6'b000100);
        layer_en = 4'b0110;
        step();
        check("pair_1_2", coll_live, 6'b001000);

        // First snapshot collects everything seen since reset.
        layer_en    = 4'b0000;
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("snap0_frame", coll_frame, 6'b111100);
        check("snap0_valid", coll_valid, 1);

        // ---- frame snapshot: pair (0,1) mid-frame ----
        layer_en = 4'b0011;
        step();
        layer_en = 4'b0000;
        step(3);
        check("hold_frame", coll_frame, 6'b111100);
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("snap1_frame", coll_frame, 6'b000001);
        check("snap1_valid", coll_valid, 1);

        // ---- quiet frame ----
        step(3);
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("snap_quiet", coll_frame, 6'b000000);

        // ---- hit on the pulse cycle belongs to the next frame ----
        layer_en    = 4'b0101;
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        layer_en    = 4'b0000;
        check("edge_hit_excl", coll_frame, 6'b000000);
        step(2);
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("edge_hit_next", coll_frame, 6'b000010);

        // ---- back-to-back pulses ----
        layer_en    = 4'b0011;
        frame_pulse = 1'b1;
        step();
        check("b2b_first", coll_frame, 6'b000000);
        layer_en = 4'b0000;
        step();
        frame_pulse = 1'b0;
        check("b2b_second", coll_frame, 6'b000001);

        // ---- async reset mid-frame ----
        layer_en = 4'b1100;
        step();
        check("pair_2_3", coll_live, 6'b100000);
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("pre_rst_frame", coll_frame, 6'b100000);
        step();
        #2;
        nRst = 1'b0;
        #1;
        check("arst_live",  coll_live,  0);
        check("arst_frame", coll_frame, 0);
        check("arst_valid", coll_valid, 0);
        check("arst_pix",   pix_out,    0);
        check("arst_hs",    hsync_out,  1);
        #1;
        nRst     = 1'b1;
        layer_en = 4'b0000;
        step(2);
        check("post_rst_valid", coll_valid, 0);
        check("post_rst_frame", coll_frame, 0);
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        check("post_rst_snap_valid", coll_valid, 1);
        check("post_rst_acc_clear",  coll_frame, 0);

`ifdef COMPOSITOR_LAYER_MASK_EN
        // ---- masked layer: not drawn, still collides ----
        set_colors(6'h3F, 6'h0C, 6'h00, 6'h00);
        layer_en   = 4'b0011;
        layer_mask = 4'b0001;
        step();
        check("mask_live0", coll_live[0], 1);
        step();
        check("mask_pix", pix_out, 6'h0C);
        layer_mask = 4'b0000;
        step(2);
        check("unmask_pix", pix_out, 6'h3F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
